// File: rtl/ir_range_sampler.sv
// IR range sensor front end: two-flop synchroniser, prescaled sampling, boxcar
// average over 2**LOG2_SAMPLES samples, and a VALID/INTER/OVERRUN read handshake.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | sampling stopped; prescaler, accumulator and counter held at 0
// ACCUM | prescaler running; one sample accumulated per tick (BUSY=1)
module ir_range_sampler #(
    parameter int SAMPLE_DIV   = 5000,
    parameter int LOG2_SAMPLES = 3,
    parameter int DATA_W       = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] IR_RAW,
    input  logic              ENABLE,
    input  logic              RD_ACK,
    output logic [DATA_W-1:0] AVG,
    output logic              VALID,
    output logic              INTER,
    output logic              OVERRUN,
    output logic              BUSY
);

    localparam int PW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam int AW = DATA_W + LOG2_SAMPLES;
    localparam logic [PW-1:0]           PRESC_LAST = PW'(SAMPLE_DIV - 1);
    localparam logic [LOG2_SAMPLES-1:0] CNT_LAST   = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t                  state, state_nx;
    logic [DATA_W-1:0]       sync_meta, sync_data;
    logic [PW-1:0]           presc, presc_nx;
    logic [AW-1:0]           acc, acc_nx, acc_sum;
    logic [LOG2_SAMPLES-1:0] cnt, cnt_nx;
    logic [DATA_W-1:0]       avg_nx;
    logic                    tick;
    logic                    done;

    // Accumulator is wide enough that the final sum never wraps.
    assign acc_sum = acc + AW'(sync_data);
    assign avg_nx  = DATA_W'(acc_sum >> LOG2_SAMPLES);

    always_comb begin
        state_nx = state;
        presc_nx = presc;
        acc_nx   = acc;
        cnt_nx   = cnt;
        tick     = 1'b0;
        done     = 1'b0;
        BUSY     = 1'b0;
        case (state)
            IDLE: begin
                if (ENABLE) state_nx = IDLE == IDLE ? ACCUM : IDLE;
            end
            ACCUM: begin
                BUSY = 1'b1;
                if (!ENABLE) begin
                    state_nx = IDLE;
                    presc_nx = '0;
                    acc_nx   = '0;
                    cnt_nx   = '0;
                end else begin
                    tick     = (presc == PRESC_LAST);
                    presc_nx = tick ? '0 : presc + 1'b1;
                    if (tick) begin
                        if (cnt == CNT_LAST) begin
                            done   = 1'b1;
                            acc_nx = '0;
                            cnt_nx = '0;
                        end else begin
                            acc_nx = acc_sum;
                            cnt_nx = cnt + 1'b1;
                        end
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            sync_meta <= '0;
            sync_data <= '0;
            presc     <= '0;
            acc       <= '0;
            cnt       <= '0;
            AVG       <= '0;
            VALID     <= 1'b0;
            INTER     <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            state     <= state_nx;
            sync_meta <= IR_RAW;
            sync_data <= sync_meta;
            presc     <= presc_nx;
            acc       <= acc_nx;
            cnt       <= cnt_nx;
            INTER     <= done;
            // An ack landing with a new result retires the old value only.
            if (done) begin
                AVG   <= avg_nx;
                VALID <= 1'b1;
                if (VALID && !RD_ACK) OVERRUN <= 1'b1;
            end else if (RD_ACK && VALID) begin
                VALID   <= 1'b0;
                OVERRUN <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ir_range_sampler.sv
// Randomised bench for ir_range_sampler (SAMPLE_DIV=4, LOG2_SAMPLES=2) checked
// against a result-level model of the average and the read handshake.
module tb_ir_range_sampler;

    localparam int DIV = 4;
    localparam int L   = 2;
    localparam int NS  = 1 << L;
    localparam int PER = NS * DIV;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] IR_RAW;
    logic       ENABLE;
    logic       RD_ACK;
    logic [7:0] AVG;
    logic       VALID;
    logic       INTER;
    logic       OVERRUN;
    logic       BUSY;

    int n_tests = 0;
    int n_fail  = 0;
    int m_avg;
    bit m_valid;
    bit m_overrun;

    ir_range_sampler #(
        .SAMPLE_DIV  (DIV),
        .LOG2_SAMPLES(L),
        .DATA_W      (8)
    ) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .IR_RAW (IR_RAW),
        .ENABLE (ENABLE),
        .RD_ACK (RD_ACK),
        .AVG    (AVG),
        .VALID  (VALID),
        .INTER  (INTER),
        .OVERRUN(OVERRUN),
        .BUSY   (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_reset();
        m_avg     = 0;
        m_valid   = 0;
        m_overrun = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_avg"},     AVG,     m_avg);
        check({tag, "_valid"},   VALID,   m_valid);
        check({tag, "_overrun"}, OVERRUN, m_overrun);
    endtask

    // Drives one full averaging window (one value held per sample period) and
    // checks the result. first=1 means ENABLE was just raised from IDLE, which
    // costs one extra cycle. ack_at 0..PER-1 pulses RD_ACK in that window
    // cycle; PER-1 coincides with the final-sample cycle.
    task automatic run_result(input bit first, input int v0, input int v1,
                              input int v2, input int v3, input int ack_at);
        int vals[4];
        int sum;
        vals = '{v0, v1, v2, v3};
        sum  = v0 + v1 + v2 + v3;
        if (first) begin
            IR_RAW = 8'(v0);
            step();
        end
        for (int i = 0; i < PER; i++) begin
            if (i % DIV == 0) IR_RAW = 8'(vals[i / DIV]);
            RD_ACK = (i == ack_at);
            step();
            RD_ACK = 1'b0;
            if (i == 0) begin
                check("busy", BUSY, 1);
                check("inter_one_cycle", INTER, 0);
            end
            if (i == PER - 2) check("inter_early", INTER, 0);
            if (i == ack_at && i < PER - 1) begin
                if (m_valid) begin
                    m_valid   = 0;
                    m_overrun = 0;
                end
                check("ack_valid",   VALID,   m_valid);
                check("ack_overrun", OVERRUN, m_overrun);
            end
        end
        if (m_valid && ack_at != PER - 1) m_overrun = 1;
        m_valid = 1;
        m_avg   = sum / NS;
        check("inter", INTER, 1);
        check_outputs("result");
    endtask

    initial begin
        int seen_inter;
        int a, b, c, d;
        model_reset();
        RESET  = 1'b1;
        ENABLE = 1'b1;
        RD_ACK = 1'b0;
        IR_RAW = 8'h80;
        step();
        step();
        check_outputs("reset");
        check("reset_inter", INTER, 0);
        check("reset_busy",  BUSY,  0);
        RESET = 1'b0;

        // Constant input: first result 17 cycles after ENABLE is seen.
        run_result(1'b1, 8'h80, 8'h80, 8'h80, 8'h80, -1);
        // Truncating average, then all-ones without wrap.
        run_result(1'b0, 8'h10, 8'h20, 8'h30, 8'h41, 3);
        check("trunc_avg", AVG, 8'h28);
        run_result(1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 5);
        check("max_avg", AVG, 8'hFF);
        // Unread result overwritten, then acked early in the next window.
        run_result(1'b0, 8'h01, 8'h02, 8'h03, 8'h04, -1);
        check("overrun_set", OVERRUN, 1);
        run_result(1'b0, 8'h11, 8'h22, 8'h33, 8'h44, 0);
        // Ack in the final-sample cycle retires the old value only.
        run_result(1'b0, 8'h55, 8'h66, 8'h77, 8'h88, PER - 1);
        check("coincident_ack_overrun", OVERRUN, 0);
        check("coincident_ack_valid",   VALID,   1);

        for (int r = 0; r < 16; r++) begin
            a = $urandom_range(0, 255);
            b = (r % 5 == 0) ? 255 : $urandom_range(0, 255);
            c = (r % 7 == 0) ? 0   : $urandom_range(0, 255);
            d = $urandom_range(0, 255);
            run_result(1'b0, a, b, c, d, $urandom_range(0, PER + 6));
        end

        // Drop ENABLE after two samples; partial sum must be discarded.
        IR_RAW = 8'h40;
        for (int i = 0; i < 2 * DIV; i++) step();
        ENABLE = 1'b0;
        step();
        check("disable_busy", BUSY, 0);
        check_outputs("disable_hold");
        IR_RAW = 8'h20;
        step();
        RD_ACK = 1'b1;
        step();
        RD_ACK = 1'b0;
        if (m_valid) begin
            m_valid   = 0;
            m_overrun = 0;
        end
        check_outputs("idle_ack");
        step();
        check("idle_busy", BUSY, 0);
        ENABLE = 1'b1;
        run_result(1'b1, 8'h20, 8'h20, 8'h20, 8'h20, -1);
        check("restart_avg", AVG, 8'h20);

        // Reset mid-window with VALID set.
        IR_RAW = 8'h99;
        for (int i = 0; i < 2 * DIV + 1; i++) step();
        RESET = 1'b1;
        step();
        model_reset();
        check_outputs("midreset");
        check("midreset_busy",  BUSY,  0);
        check("midreset_inter", INTER, 0);
        RESET  = 1'b0;
        ENABLE = 1'b0;
        seen_inter = 0;
        for (int i = 0; i < 2 * PER; i++) begin
            step();
            if (INTER) seen_inter++;
        end
        check("midreset_no_inter", seen_inter, 0);
        check("midreset_idle_busy", BUSY, 0);
        ENABLE = 1'b1;
        run_result(1'b1, $urandom_range(0, 255), $urandom_range(0, 255),
                   $urandom_range(0, 255), $urandom_range(0, 255), -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ir_range_sampler.md
Name: ir_range_sampler

Overview:
- Front-end conditioning stage between the 8-bit IR range sensor pins and the MCU input-port mux (IRSENSOR_ID, 0xA6).
- Synchronises the asynchronous sensor bus and samples it at a programmable rate.
- Boxcar-averages 2^LOG2_SAMPLES samples and presents a stable 8-bit result, a valid flag, and a one-cycle interrupt pulse when each new average is ready.
- The MCU acknowledges each read with RD_ACK, decoded in the wrapper from an IN on port 0xA6.

Parameters:
- SAMPLE_DIV, 5000: CLK cycles between samples; legal range ≥2.
- LOG2_SAMPLES, 3: log2 of the number of samples averaged (8); legal range 1..6.
- DATA_W, 8: sensor and result width.

Ports:
- CLK  in  1  system clock (the 50 MHz MCU clock domain).
- RESET  in  1  synchronous, active-high reset.
- IR_RAW  in  DATA_W  asynchronous sensor bus.
- ENABLE  in  1  run sampling when high.
- RD_ACK  in  1  one-cycle pulse; MCU has consumed AVG.
- AVG  out  DATA_W  latest averaged result, held between updates.
- VALID  out  1  unread result present.
- INTER  out  1  one-cycle pulse per new result; ORed into the MCU INTERRUPT.
- OVERRUN  out  1  sticky; a result was overwritten while unread.
- BUSY  out  1  high in ACCUM state.

Behaviour:
- Reset (synchronous, all registers):
  - AVG=0, VALID=0, INTER=0, OVERRUN=0, BUSY=0.
  - State=IDLE; prescaler, accumulator and sample counter = 0.
  - Synchroniser flops = 0.
  - Reset mid-accumulation discards the partial sum.
- Synchroniser: two-flop on IR_RAW, giving sync_data with 2-cycle latency. Only sync_data feeds the datapath.
- Prescaler:
  - Counts 0..SAMPLE_DIV-1 while in ACCUM, then wraps to 0.
  - tick is asserted in the cycle the count equals SAMPLE_DIV-1.
  - Held at 0 outside ACCUM.
- Accumulator: width DATA_W+LOG2_SAMPLES, so it cannot overflow (all-ones input gives 0xFF<<LOG2, exactly representable). Sample counter width LOG2_SAMPLES.
- State machine:
  - IDLE: BUSY=0. ENABLE=1 → ACCUM next cycle.
  - ACCUM: BUSY=1. On tick with counter < 2^L-1: acc += sync_data, counter++.
  - ACCUM, on tick with counter == 2^L-1 (the final sample):
    - AVG <= (acc+sync_data) >> LOG2_SAMPLES, i.e. truncating divide with no rounding.
    - acc <= 0 and counter <= 0; remain in ACCUM.
    - Assert done for that cycle.
  - ACCUM with ENABLE=0: → IDLE next cycle. Clear acc, counter and prescaler. AVG, VALID and OVERRUN are held.
- Result handshake (evaluated in the cycle done is asserted):
  - INTER=1 in the cycle after done, for exactly one cycle.
  - VALID <= 1.
  - If VALID was already 1 and RD_ACK=0 in the done cycle: OVERRUN <= 1.
  - If RD_ACK=1 in the done cycle: VALID stays 1 and OVERRUN is not set, because the ack applies to the old value.
- RD_ACK without done: VALID <= 0 and OVERRUN <= 0 next cycle. RD_ACK while VALID=0 has no effect.
- Latency: first result is ready 1 + 2^L·SAMPLE_DIV cycles after ENABLE is seen high. Subsequent results follow every 2^L·SAMPLE_DIV cycles.
- ENABLE re-assert after IDLE starts a fresh average from counter 0.

Test Plan:
1. SAMPLE_DIV=4, LOG2=2; RESET 2 cycles; IR_RAW=0x80 constant; ENABLE=1 → all outputs 0 during reset. First INTER pulse 17 cycles after ENABLE; AVG=0x80, VALID=1, INTER high exactly one cycle.
2. Sequence 0x10,0x20,0x30,0x41, held one per sample period → sum 0xA1, AVG=0x28 (truncation). Then all 0xFF → AVG=0xFF, no wrap.
3. Leave VALID=1 without RD_ACK through a second result → OVERRUN=1 and AVG updated. Then pulse RD_ACK → VALID=0, OVERRUN=0 next cycle.
4. RD_ACK coincident with the done cycle → VALID remains 1, OVERRUN remains 0, AVG holds the new value.
5. Drop ENABLE after 2 of 4 samples (0x40,0x40), then re-enable with 0x20 constant → BUSY falls; previous AVG held; next AVG=0x20 (partial sum discarded).
6. Assert RESET in the middle of ACCUM with VALID=1 → next cycle AVG=0, VALID=0, OVERRUN=0, BUSY=0, state IDLE; no INTER pulse emitted.
